// File: rtl/ctr_pr_dec.sv
// Sequential decoder: pseudo-random counter state to binary step index.
// Define CTR_PR_DEC_BIDIR_EN for a two-ended (forward + backward) search.
module ctr_pr_dec #(
  parameter int            N    = 5,
  parameter logic [N-1:0]  TAPS = 5'b10100
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] code,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] index,
  output logic         err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] SEARCH = 1'b1;

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONES = '1;
  localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] PM1  = {{(N-1){1'b1}}, 1'b0};

  function automatic logic [N-1:0] step_f(
    input logic [N-1:0] s
  );
    step_f = {s[N-2:0], ~^(s & TAPS)};
  endfunction

  // Undo one step: the shifted-out MSB is rebuilt from fb and the low taps.
  function automatic logic [N-1:0] unstep_f(
    input logic [N-1:0] s
  );
    logic [N-1:0] lo;
    lo       = {1'b0, s[N-1:1]};
    unstep_f = {s[0] ^ ~^(lo & TAPS), s[N-1:1]};
  endfunction

  logic [0:0]   state_q, state_d;
  logic [N-1:0] target_q, target_d;
  logic [N-1:0] w_q, w_d;
  logic [N-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic [N-1:0] index_q, index_d;
  logic         err_q, err_d;

`ifdef CTR_PR_DEC_BIDIR_EN
  logic [N-1:0] v_q, v_d;
  logic [N-1:0] dcnt_q, dcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    w_d      = w_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    index_d  = index_q;
    err_d    = err_q;
`ifdef CTR_PR_DEC_BIDIR_EN
    v_d      = v_q;
    dcnt_d   = dcnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          target_d = code;
          w_d      = ZERO;
          cnt_d    = ZERO;
          busy_d   = 1'b1;
          state_d  = SEARCH;
`ifdef CTR_PR_DEC_BIDIR_EN
          v_d      = unstep_f(ZERO);
          dcnt_d   = PM1;
`endif
        end
      end
      SEARCH: begin
        if (w_q == target_q) begin
          index_d = cnt_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef CTR_PR_DEC_BIDIR_EN
        end else if (v_q == target_q) begin
          index_d = dcnt_q;
          err_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_q == dcnt_q) begin
`else
        end else if (cnt_q == PM1) begin
`endif
          index_d = ONES;
          err_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          w_d   = step_f(w_q);
          cnt_d = cnt_q + ONE;
`ifdef CTR_PR_DEC_BIDIR_EN
          v_d    = unstep_f(v_q);
          dcnt_d = dcnt_q - ONE;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= ZERO;
      w_q      <= ZERO;
      cnt_q    <= ZERO;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      index_q  <= ZERO;
      err_q    <= 1'b0;
`ifdef CTR_PR_DEC_BIDIR_EN
      v_q      <= ZERO;
      dcnt_q   <= ZERO;
`endif
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      w_q      <= w_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      index_q  <= index_d;
      err_q    <= err_d;
`ifdef CTR_PR_DEC_BIDIR_EN
      v_q      <= v_d;
      dcnt_q   <= dcnt_d;
`endif
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign index = index_q;
  assign err   = err_q;

endmodule

// File: doc/ctr_pr_dec.md
# ctr_pr_dec

Sequential decoder for the team's shift-register pseudo-random counters: converts an N-bit pseudo-random counter state back into its binary step index. It sits beside a pseudo-random counter wherever a captured count must be reported in binary (timestamps, debug readout, host registers). It works by walking its own copy of the same sequence from the all-zero seed until it matches the requested code, and uses a start/done handshake.

## Interface
- `N`, default 5: state width in bits; sequence period P = 2^N − 1.
- `TAPS`, default 5'b10100: feedback tap mask. Bit N−1 must be set. For the default (x^5+x^3+1), the feedback taps are bits 4 and 2.
- `clk` input 1: clock; every state element updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request a decode; sampled only while idle.
- `code` input N: counter state to decode; sampled on the edge that accepts `start`.
- `busy` output 1: high from the accepting edge until `done` is issued.
- `done` output 1: single-cycle pulse; `index` and `err` are valid in the same cycle.
- `index` output N: decoded step count. It holds its value until the next `done`.
- `err` output 1: code is not on the sequence (lockup state). Valid with `done` and held until the next `done`.

## Operation
- Sequence definition, forward step:
  - `s <= {s[N-2:0], fb}`, where `fb = ~^(s & TAPS)` (XNOR of the tapped bits).
  - Seed is 0; index k is the state after k steps.
  - Lockup state is all-ones and maps to itself.
- States: IDLE and SEARCH.
- IDLE:
  - `start=1` captures `code` into `target`.
  - Sets walker `w=0` and counter `cnt=0`.
  - Sets `busy=1` and moves to SEARCH.
- SEARCH, evaluated each edge:
  - If `w==target`: `index<=cnt`, `err<=0`, `done<=1`, `busy<=0`, go to IDLE.
  - Else if `cnt==P-1`: `index<=all-ones`, `err<=1`, `done<=1`, `busy<=0`, go to IDLE.
  - Else: `w<=step(w)` and `cnt<=cnt+1`.
- `cnt` never exceeds P−1; it needs no wrap logic.
- `start` while busy is ignored; no queueing.
- `start` on the same edge that issues `done` is ignored. The earliest accepted `start` is the cycle after `done`.
- `code` changes after acceptance have no effect.
- Reset at any time:
  - Returns the block to IDLE.
  - Outputs `busy=0`, `done=0`, `err=0`, `index=0`.
  - Any search in flight is discarded and produces no `done`.

## Timing
- Let E0 be the edge that accepts `start`. A code at index k produces `done` high in the cycle after edge E0+1+k. Latency is k+1 edges after E0.
- Index 0 → `done` after E1. Index P−1 → after EP.
- Lockup/err → after EP, the same latency as index P−1.
- `busy` falls on the same edge that raises `done`.
- `done` is low in every other cycle.

## Configuration
- Macro `CTR_PR_DEC_BIDIR_EN` enables bidirectional search. Undefined means the forward-only behaviour above.
- Defined:
  - A second walker `v` starts at `step⁻¹(0)` with counter `dcnt=P-1`.
  - Each SEARCH edge applies `v<=step⁻¹(v)` and `dcnt<=dcnt-1` in parallel with the forward walker.
  - `step⁻¹(s) = {s[0] ^ ~^(({1'b0,s[N-1:1]}) & TAPS & ~(1<<(N-1))) ... }`, implemented as: shift right, then recover the lost MSB from `fb` and the remaining taps.
- Termination when defined:
  - A backward match reports `index=dcnt`.
  - If both walkers match on the same edge, the forward result wins.
  - Err fires when `cnt` reaches `dcnt` without a match: after edge E0+1+⌈(P−1)/2⌉, which is E16 for N=5.
- Worst-case latency is about P/2 edges.
- Outputs, handshake and reset behaviour are identical with and without the macro.

## Test plan
All scenarios use N=5, TAPS=5'b10100, P=31.
- `code=5'b00000`, pulse `start` → `done` after E1, `index=0`, `err=0`, `busy` high for exactly 1 cycle.
- `code=5'b00111` → `index=3`, `done` after E4. Also check `5'b01110` → `index=4`.
- `code=5'b11111` (lockup) → `done` after E31 with `err=1` and `index=5'b11111`. With `CTR_PR_DEC_BIDIR_EN`, the same outputs arrive after E16.
- `code=5'b10000` → `index=30`: `done` after E31 forward-only, after E1 with `CTR_PR_DEC_BIDIR_EN`.
- During a search for `5'b00111`, assert `start` with `code=0` at E2 → ignored; the result is still `index=3` after E4.
- `rst_n` low at E2 of a search for index 20 → `busy`, `done` and `index` go to 0 immediately. No `done` follows; the next `start` decodes normally.
- Sweep all 31 sequence states generated by a reference model → each returns its own index with `err=0`.
